// File: rtl/gol_pkg.sv
// Shared types and constants for the Game-of-Life board engine.
package gol_pkg;

  // Engine operating modes.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_STEP   = 3'd2,
    ST_COMMIT = 3'd3,
    ST_READ   = 3'd4
  } state_e;

  // B3/S23 rule thresholds on the live-neighbour count.
  localparam logic [3:0] BIRTH_COUNT   = 4'd3;
  localparam logic [3:0] SURVIVE_COUNT = 4'd2;

  // Bits needed to address every cell of a w x h board.
  function automatic int unsigned idx_width(input int unsigned w, input int unsigned h);
    return $unsigned($clog2(w * h));
  endfunction

endpackage

// File: rtl/gol_cell_rule.sv
// Combinational B3/S23 next-state for one cell given its eight neighbours.
module gol_cell_rule (
  input  logic       alive_i,
  input  logic [7:0] nbr_i,
  output logic       next_c
);
  import gol_pkg::*;

  logic [3:0] count;

  // Population count of the neighbourhood, then apply birth/survival.
  always_comb begin
    count = 4'd0;
    for (int k = 0; k < 8; k++) begin
      count = count + 4'(nbr_i[k]);
    end
    next_c = (count == BIRTH_COUNT) | (alive_i & (count == SURVIVE_COUNT));
  end

endmodule

// File: rtl/gol_board_stepper.sv
// Toroidal Game-of-Life board: serial load, one-cell-per-cycle step into a
// shadow board with a single commit, and valid/ready raster readout.
module gol_board_stepper #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned HEIGHT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_start,
  input  logic        load_valid,
  input  logic        load_data,
  output logic        load_ready,
  input  logic        step_start,
  input  logic        read_start,
  output logic        rd_valid,
  output logic        rd_data,
  output logic        rd_last,
  input  logic        rd_ready,
  output logic        busy,
  output logic [15:0] generation,
  output logic        step_done
);
  import gol_pkg::*;

  localparam int unsigned N  = WIDTH * HEIGHT;
  localparam int unsigned IW = idx_width(WIDTH, HEIGHT);
  localparam int unsigned RW = $clog2(HEIGHT);
  localparam int unsigned CW = $clog2(WIDTH);

  state_e                         state_q, state_d;
  logic [IW-1:0]                  idx_q, idx_d;
  logic [RW-1:0]                  row_q, row_d;
  logic [CW-1:0]                  col_q, col_d;
  logic [N-1:0]                   board_q, board_d;
  logic [HEIGHT-1:0][WIDTH-1:0]   shadow_q, shadow_d;
  logic [15:0]                    gen_q, gen_d;
  logic                           load_ready_q, load_ready_d;
  logic                           rd_valid_q, rd_valid_d;
  logic                           rd_data_q, rd_data_d;
  logic                           rd_last_q, rd_last_d;
  logic                           busy_q, busy_d;
  logic                           step_done_q, step_done_d;

  logic [HEIGHT-1:0][WIDTH-1:0]   board_rc;
  logic [RW-1:0]                  row_m1, row_p1;
  logic [CW-1:0]                  col_m1, col_p1;
  logic [7:0]                     nbr;
  logic                           next_cell;

  assign board_rc = board_q;

  // Wrapped neighbour coordinates of the cell under the scan.
  always_comb begin
    row_m1 = (row_q == '0) ? RW'(HEIGHT - 1) : row_q - RW'(1);
    row_p1 = (row_q == RW'(HEIGHT - 1)) ? '0 : row_q + RW'(1);
    col_m1 = (col_q == '0) ? CW'(WIDTH - 1) : col_q - CW'(1);
    col_p1 = (col_q == CW'(WIDTH - 1)) ? '0 : col_q + CW'(1);
    nbr    = {board_rc[row_m1][col_m1], board_rc[row_m1][col_q], board_rc[row_m1][col_p1],
              board_rc[row_q][col_m1],                           board_rc[row_q][col_p1],
              board_rc[row_p1][col_m1], board_rc[row_p1][col_q], board_rc[row_p1][col_p1]};
  end

  gol_cell_rule u_rule (
    .alive_i (board_rc[row_q][col_q]),
    .nbr_i   (nbr),
    .next_c  (next_cell)
  );

  // Mode sequencing, board/shadow updates and registered output preparation.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    row_d     = row_q;
    col_d     = col_q;
    board_d   = board_q;
    shadow_d  = shadow_q;
    gen_d     = gen_q;
    rd_valid_d = rd_valid_q;
    rd_data_d  = rd_data_q;
    rd_last_d  = rd_last_q;

    case (state_q)
      ST_IDLE: begin
        if (load_start) begin
          state_d = ST_LOAD;
          idx_d   = '0;
        end else if (step_start) begin
          state_d = ST_STEP;
          row_d   = '0;
          col_d   = '0;
        end else if (read_start) begin
          state_d    = ST_READ;
          idx_d      = '0;
          rd_valid_d = 1'b1;
          rd_data_d  = board_q[0];
          rd_last_d  = 1'b0;
        end
      end
      ST_LOAD: begin
        if (load_valid && load_ready_q) begin
          board_d[idx_q] = load_data;
          if (idx_q == IW'(N - 1)) begin
            state_d = ST_IDLE;
            gen_d   = '0;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      ST_STEP: begin
        shadow_d[row_q][col_q] = next_cell;
        if (col_q == CW'(WIDTH - 1)) begin
          col_d = '0;
          if (row_q == RW'(HEIGHT - 1)) begin
            row_d   = '0;
            state_d = ST_COMMIT;
          end else begin
            row_d = row_q + RW'(1);
          end
        end else begin
          col_d = col_q + CW'(1);
        end
      end
      ST_COMMIT: begin
        board_d = shadow_q;
        gen_d   = gen_q + 16'd1;
        state_d = ST_IDLE;
      end
      ST_READ: begin
        if (rd_valid_q && rd_ready) begin
          if (rd_last_q) begin
            state_d    = ST_IDLE;
            rd_valid_d = 1'b0;
            rd_last_d  = 1'b0;
          end else begin
            idx_d     = idx_q + IW'(1);
            rd_data_d = board_q[idx_d];
            rd_last_d = (idx_d == IW'(N - 1));
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    load_ready_d = (state_d == ST_LOAD);
    busy_d       = (state_d != ST_IDLE);
    step_done_d  = (state_q == ST_COMMIT);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      row_q        <= '0;
      col_q        <= '0;
      board_q      <= '0;
      shadow_q     <= '0;
      gen_q        <= '0;
      load_ready_q <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_data_q    <= 1'b0;
      rd_last_q    <= 1'b0;
      busy_q       <= 1'b0;
      step_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      row_q        <= row_d;
      col_q        <= col_d;
      board_q      <= board_d;
      shadow_q     <= shadow_d;
      gen_q        <= gen_d;
      load_ready_q <= load_ready_d;
      rd_valid_q   <= rd_valid_d;
      rd_data_q    <= rd_data_d;
      rd_last_q    <= rd_last_d;
      busy_q       <= busy_d;
      step_done_q  <= step_done_d;
    end
  end

  assign load_ready = load_ready_q;
  assign rd_valid   = rd_valid_q;
  assign rd_data    = rd_data_q;
  assign rd_last    = rd_last_q;
  assign busy       = busy_q;
  assign generation = gen_q;
  assign step_done  = step_done_q;

endmodule

// File: tb/tb_gol_board_stepper.sv
// Bench for gol_board_stepper on the default 8x8 board.
module tb_gol_board_stepper;

  localparam int N = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_start, load_valid, load_data, load_ready;
  logic        step_start, read_start;
  logic        rd_valid, rd_data, rd_last, rd_ready;
  logic        busy, step_done;
  logic [15:0] generation;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    string       name;
    logic [63:0] init;
    int          steps;
    logic [63:0] exp_board;
    logic [15:0] exp_gen;
  } vec_t;

  gol_board_stepper #(.WIDTH(8), .HEIGHT(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_start (load_start),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .step_start (step_start),
    .read_start (read_start),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .rd_last    (rd_last),
    .rd_ready   (rd_ready),
    .busy       (busy),
    .generation (generation),
    .step_done  (step_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference generation: count the eight torus neighbours of every cell directly.
  function automatic logic [63:0] model_step(input logic [63:0] b);
    logic [63:0] nb;
    int cnt, rr, cc;
    nb = '0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        cnt = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if (dr != 0 || dc != 0) begin
              rr  = (r + dr + 8) % 8;
              cc  = (c + dc + 8) % 8;
              cnt = cnt + int'(b[rr * 8 + cc]);
            end
          end
        end
        nb[r * 8 + c] = (cnt == 3) || (b[r * 8 + c] && cnt == 2);
      end
    end
    return nb;
  endfunction

  task automatic load_board(input logic [63:0] b, input bit gaps, input bit inject,
                            input bit with_step, output int cycles);
    int i;
    int guard;
    i = 0;
    guard = 0;
    load_start = 1'b1;
    step_start = with_step;
    tick();
    load_start = 1'b0;
    step_start = 1'b0;
    check("load_ready_on_entry", 64'(load_ready), 64'd1);
    while (i < N && guard < 1000) begin
      load_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      load_data  = b[i];
      if (inject && i == 10) begin
        step_start = 1'b1;
        read_start = 1'b1;
      end
      if (load_valid && load_ready) i++;
      tick();
      guard++;
      step_start = 1'b0;
      read_start = 1'b0;
    end
    load_valid = 1'b0;
    cycles = guard;
    check("load_cells_accepted", 64'(i), 64'(N));
    check("load_exit_idle", 64'({load_ready, busy}), 64'd0);
    check("load_gen_clear", 64'(generation), 64'd0);
  endtask

  task automatic step_once(input logic [15:0] exp_gen);
    int cyc;
    step_start = 1'b1;
    tick();
    step_start = 1'b0;
    check("step_busy", 64'(busy), 64'd1);
    cyc = 0;
    while (!step_done && cyc < 200) begin
      tick();
      cyc++;
    end
    check("step_latency", 64'(cyc), 64'd65);
    check("step_busy_fall", 64'(busy), 64'd0);
    check("step_generation", 64'(generation), 64'(exp_gen));
    tick();
    check("step_done_pulse", 64'(step_done), 64'd0);
  endtask

  task automatic read_board(input bit backpressure, output logic [63:0] got, output int cycles);
    int   cnt, guard, bad_stable, bad_last;
    logic pv, pr, pd, pl;
    got = '0;
    cnt = 0;
    guard = 0;
    bad_stable = 0;
    bad_last = 0;
    pv = 1'b0; pr = 1'b0; pd = 1'b0; pl = 1'b0;
    read_start = 1'b1;
    tick();
    read_start = 1'b0;
    while (cnt < N && guard < 2000) begin
      rd_ready = backpressure ? 1'($urandom_range(0, 1)) : 1'b1;
      if (pv && !pr && (!rd_valid || rd_data !== pd || rd_last !== pl)) bad_stable++;
      if (rd_valid && rd_ready) begin
        got[cnt] = rd_data;
        if (rd_last !== (cnt == N - 1)) bad_last++;
        cnt++;
      end
      pv = rd_valid; pr = rd_ready; pd = rd_data; pl = rd_last;
      tick();
      guard++;
    end
    rd_ready = 1'b0;
    cycles = guard;
    check("read_cell_count", 64'(cnt), 64'(N));
    check("read_stall_stable", 64'(bad_stable), 64'd0);
    check("read_last_position", 64'(bad_last), 64'd0);
    check("read_exit_idle", 64'({rd_valid, busy}), 64'd0);
  endtask

  initial begin
    vec_t        vecs[5];
    logic [63:0] got, b, m;
    int          cyc, nsteps;

    vecs[0] = '{"blinker",      64'h0000_0404_0400_0000, 1, 64'h0000_000E_0000_0000, 16'd1};
    vecs[1] = '{"block",        64'h0000_0000_0000_0303, 3, 64'h0000_0000_0000_0303, 16'd3};
    vecs[2] = '{"glider_wrap",  64'h0180_0000_0000_00C1, 4, 64'h0100_0000_0000_8302, 16'd4};
    vecs[3] = '{"empty",        64'h0,                   1, 64'h0,                   16'd1};
    vecs[4] = '{"full",         64'hFFFF_FFFF_FFFF_FFFF, 1, 64'h0,                   16'd1};

    rst = 1'b1;
    load_start = 1'b0; load_valid = 1'b0; load_data = 1'b0;
    step_start = 1'b0; read_start = 1'b0; rd_ready = 1'b0;
    repeat (3) tick();
    check("reset_load_ready", 64'(load_ready), 64'd0);
    check("reset_rd_valid",   64'(rd_valid),   64'd0);
    check("reset_rd_data",    64'(rd_data),    64'd0);
    check("reset_rd_last",    64'(rd_last),    64'd0);
    check("reset_busy",       64'(busy),       64'd0);
    check("reset_generation", 64'(generation), 64'd0);
    check("reset_step_done",  64'(step_done),  64'd0);
    rst = 1'b0;
    tick();
    read_board(0, got, cyc);
    check("reset_board_zero", got, 64'd0);

    // Known patterns with hand-derived results.
    for (int v = 0; v < 5; v++) begin
      load_board(vecs[v].init, 1, 0, 0, cyc);
      for (int s = 1; s <= vecs[v].steps; s++) step_once(16'(s));
      read_board(1, got, cyc);
      check(vecs[v].name, got, vecs[v].exp_board);
      check("table_generation", 64'(generation), 64'(vecs[v].exp_gen));
    end

    // Random boards against the reference model.
    for (int r = 0; r < 8; r++) begin
      b = {$urandom, $urandom};
      nsteps = $urandom_range(1, 3);
      m = b;
      load_board(b, 1, 0, 0, cyc);
      for (int s = 1; s <= nsteps; s++) begin
        step_once(16'(s));
        m = model_step(m);
      end
      read_board(1, got, cyc);
      check("random_board", got, m);
    end

    // Commands during LOAD are dropped; full-rate load and read.
    b = {$urandom, $urandom};
    load_board(b, 0, 1, 0, cyc);
    check("load_throughput", 64'(cyc), 64'd64);
    read_board(0, got, cyc);
    check("read_throughput", 64'(cyc), 64'd64);
    check("loaded_board_intact", got, b);

    // Simultaneous load+step in IDLE starts only LOAD and clears the generation.
    step_once(16'd1);
    b = {$urandom, $urandom};
    load_board(b, 1, 0, 1, cyc);
    read_board(1, got, cyc);
    check("pair_load_board", got, b);
    check("pair_generation", 64'(generation), 64'd0);

    // Reset part-way through a step aborts it with no commit.
    b = {$urandom, $urandom};
    load_board(b, 1, 0, 0, cyc);
    step_once(16'd1);
    step_start = 1'b1;
    tick();
    step_start = 1'b0;
    repeat (29) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midstep_reset_busy", 64'(busy), 64'd0);
    check("midstep_reset_gen",  64'(generation), 64'd0);
    repeat (40) tick();
    check("midstep_no_commit", 64'({busy, step_done, generation}), 64'd0);
    read_board(1, got, cyc);
    check("midstep_board_zero", got, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/gol_board_stepper.md
# gol_board_stepper

Sequential board engine that supplies the per-cell Game-of-Life next-state rule with its eight neighbour states and collects its results. It holds a WIDTH×HEIGHT toroidal board, accepts an initial pattern as a serial raster stream, and advances one generation per step command by scanning one cell per cycle into a shadow board. It streams the current board back out on a valid/ready port. It sits between the host/loader logic and the display/readout path.

## Interface
- WIDTH, 8, board columns (≥3)
- HEIGHT, 8, board rows (≥3)
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- load_start  in  1  pulse: begin loading a new board (ignored unless idle)
- load_valid  in  1  load_data is valid
- load_data  in  1  cell value, raster order (row 0 col 0 first, column fastest)
- load_ready  out  1  high while loading and the engine accepts a cell
- step_start  in  1  pulse: compute one generation (ignored unless idle)
- read_start  in  1  pulse: stream the current board out (ignored unless idle)
- rd_valid  out  1  rd_data is valid
- rd_data  out  1  cell value, raster order
- rd_last  out  1  high with the final cell (index WIDTH*HEIGHT-1)
- rd_ready  in  1  consumer accepts rd_data
- busy  out  1  high in any state other than IDLE
- generation  out  16  generations computed since the last load or reset; wraps 0xFFFF→0
- step_done  out  1  one-cycle pulse when a step commits

## Operation
- Cell index i = row*WIDTH + col; board bit i holds that cell; 1 = alive.
- States: IDLE, LOAD, STEP, COMMIT, READ.
- IDLE: accepts exactly one command per cycle. If more than one is asserted, priority is load_start > step_start > read_start. Commands in any other state are dropped.
- LOAD: load_ready=1. Each load_valid&load_ready cycle writes board[idx] and increments idx. After cell WIDTH*HEIGHT-1 is accepted, go to IDLE and clear generation to 0.
- STEP: one cell per cycle, idx 0..N-1, where N = WIDTH*HEIGHT.
  - Neighbours are taken from the current board with toroidal wrap: col-1 of col 0 is WIDTH-1, row+1 of HEIGHT-1 is 0.
  - Rule (B3/S23): next = (count==3) | (alive & count==2), where count is the 4-bit number of live neighbours.
  - Results go to the shadow board. The current board is unchanged during STEP.
- COMMIT: copies shadow to board, increments generation, pulses step_done, then goes to IDLE.
- READ: presents board[idx] on rd_data with rd_valid=1. On each rd_valid&rd_ready, idx increments. rd_last is high for idx = N-1. The handshake on the last cell returns to IDLE.
- rd_data, rd_last and rd_valid hold stable while rd_valid=1 and rd_ready=0.

## Timing
- Reset values:
  - Outputs: load_ready=0, rd_valid=0, rd_data=0, rd_last=0, busy=0, generation=0, step_done=0.
  - Internal: board=0, shadow=0, idx=0, state=IDLE.
- A command sampled at edge k sets busy=1 from cycle k+1.
- Step latency: N STEP cycles plus 1 COMMIT cycle.
  - step_done and the updated board and generation are visible in the cycle after COMMIT.
  - busy falls in that same cycle.
  - An 8×8 board takes 65 cycles from step_start to step_done.
- Load and read throughput is 1 cell/cycle with no bubbles when the partner is always ready or valid.
- Reset asserted mid-LOAD, mid-STEP or mid-READ aborts the operation. The board returns to all-zero; no partial commit occurs.

## Structure
- Package gol_pkg holds:
  - the state enum
  - the function computing the cell index width as $clog2(WIDTH*HEIGHT)
  - the rule constants BIRTH_COUNT=3 and SURVIVE_COUNT=2
- Sub-module gol_cell_rule is purely combinational. Inputs: alive plus 8 neighbours. Output: the next state. One instance is shared across the scan.
- Neighbour address generation (row/col counters with wrap) lives in the top module. Row and column are kept as separate counters; idx is never divided by WIDTH.

## Test plan
- Blinker, 8×8: load cells 26, 34, 42 (col 2, rows 3–5), step → read returns exactly cells 33, 34, 35 alive; generation=1; step_done 65 cycles after step_start.
- Block still life: load cells 0, 1, 8, 9, step 3 times → board unchanged, generation=3.
- Wrap: load a glider straddling col 7/col 0 and row 7/row 0, step 4 times → glider is translated by (+1,+1) modulo 8, matching the golden model.
- Backpressure: during READ, toggle rd_ready randomly → 64 cells received in order, rd_data stable while stalled, rd_last only on the 64th.
- Command hygiene: assert step_start and read_start during LOAD, and load_start+step_start together in IDLE → busy commands ignored; the simultaneous pair starts LOAD only.
- Reset mid-STEP at cycle 30 → next cycle busy=0, generation=0; a subsequent read returns all zeros.
